// File: rtl/counter_pkg.sv
// Shared encodings for the up/down modulo counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_ONESHOT  = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_prescaler.sv
// Tick prescaler: strobes on the last of every PRESCALE enabled cycles.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic strobe
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  // With PRESCALE = 1 the phase register is constant and the strobe is tied high.
  assign strobe = (PRESCALE == 1) ? 1'b1 : (r_cnt == LAST);

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with load, enable, prescaler and
// wrap / saturate / ping-pong / one-shot behaviour at the count bounds.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 2**WIDTH - 1,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             tc,
  output logic             dir,
  output logic             halted
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] r_result;
  logic             r_tc;
  logic             r_dir;
  logic             r_halted;

  mode_e            w_mode;
  logic             w_strobe;
  logic             w_tick;
  logic             w_dir;
  logic             w_at_bound;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_next_result;
  logic             w_next_tc;
  logic             w_next_dir;
  logic             w_next_halted;

  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .clear  (load),
    .strobe (w_strobe)
  );

  assign w_mode         = mode_e'(mode);
  assign w_tick         = en & w_strobe;
  assign w_dir          = (w_mode == MODE_PINGPONG) ? r_dir : up_down;
  assign w_at_bound     = (w_dir == DIR_UP) ? (r_result == MAXV) : (r_result == '0);
  assign w_step         = (w_dir == DIR_UP) ? r_result + WIDTH'(1) : r_result - WIDTH'(1);
  assign w_load_clamped = (load_value > MAXV) ? MAXV : load_value;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_result = r_result;
    w_next_tc     = 1'b0;
    w_next_dir    = r_dir;
    w_next_halted = r_halted;
    // A halted one-shot ignores ticks in any mode until load or reset.
    if (w_tick && !r_halted) begin
      w_next_result = w_step;
      if (w_at_bound) begin
        w_next_tc = 1'b1;
        case (w_mode)
          MODE_WRAP:     w_next_result = (w_dir == DIR_UP) ? '0 : MAXV;
          MODE_SAT:      w_next_result = r_result;
          MODE_PINGPONG: begin
            w_next_result = (w_dir == DIR_UP) ? MAXV - WIDTH'(1) : WIDTH'(1);
            w_next_dir    = ~r_dir;
          end
          MODE_ONESHOT: begin
            w_next_result = r_result;
            w_next_halted = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_tc     <= 1'b0;
      r_dir    <= DIR_UP;
      r_halted <= 1'b0;
    end else if (load) begin
      r_result <= w_load_clamped;
      r_tc     <= 1'b0;
      r_dir    <= up_down;
      r_halted <= 1'b0;
    end else begin
      r_result <= w_next_result;
      r_tc     <= w_next_tc;
      r_dir    <= w_next_dir;
      r_halted <= w_next_halted;
    end
  end

  assign result = r_result;
  assign tc     = r_tc;
  assign dir    = w_dir;
  assign halted = r_halted;

endmodule
